cmd_data_controller: RTL and testbench

- UART-side command engine between the serial RX/TX byte stream and a parametrised, multi-channel sample memory read port.
- Decodes one-byte opcodes and collects multi-byte arguments; fetches words with a fixed read latency and serialises them MSB-byte-first to the transmitter under busy flow control.
- Adds single read, full burst, ranged burst, channel select and drop toggle, plus an RX argument timeout.

---
 rtl/cmd_pkg.sv | 25 ++
 rtl/word_serializer.sv | 63 ++++++
 rtl/cmd_data_controller.sv | 180 ++++++++++++++++++
 tb/tb_cmd_data_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared opcodes, debug codes and FSM state encoding for the UART command engine.
package cmd_pkg;

    localparam logic [7:0] OP_SINGLE   = 8'h04;
    localparam logic [7:0] OP_BURST    = 8'h05;
    localparam logic [7:0] OP_RANGE    = 8'h06;
    localparam logic [7:0] OP_CHAN     = 8'h07;
    localparam logic [7:0] OP_DROP     = 8'h42;
    localparam logic [7:0] DBG_TIMEOUT = 8'hEE;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        GET_ARG,
        FETCH,
        SEND,
        NEXT
    } state_t;

    // Number of bytes needed to carry an address/count argument.
    function automatic int arg_bytes(input int addr_w);
        return (addr_w + 7) / 8;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Sends one memory word MSB byte first, one byte per non-busy cycle, with a gap
// cycle after every strobe so a transmitter whose busy lags by one cycle is respected.
module word_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_busy,
    output logic              o_new_data_tx,
    output logic [7:0]        o_data_tx,
    output logic              o_done
);

    localparam int NB = DATA_W / 8;
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_SEND,
        SER_GAP
    } ser_state_t;

    ser_state_t        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SER_IDLE;
            r_shift <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                SER_IDLE: begin
                    if (i_load) begin
                        r_shift <= i_word;
                        r_left  <= BW'(NB);
                        r_state <= SER_SEND;
                    end
                end
                SER_SEND: begin
                    if (!i_busy) begin
                        r_shift <= r_shift << 8;
                        r_left  <= r_left - 1'b1;
                        r_state <= SER_GAP;
                    end
                end
                SER_GAP: begin
                    r_state <= (r_left == '0) ? SER_IDLE : SER_SEND;
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    // The strobe follows busy combinationally so no byte is ever offered while busy is high.
    assign o_new_data_tx = (r_state == SER_SEND) && !i_busy;
    assign o_data_tx     = r_shift[DATA_W-1 -: 8];
    assign o_done        = (r_state == SER_GAP) && (r_left == '0);

endmodule

// File: rtl/cmd_data_controller.sv
// UART command engine: decodes opcodes, collects arguments and streams memory
// words to the transmitter (single read, full burst, ranged burst, channel, drop).
module cmd_data_controller
    import cmd_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int CHANNELS       = 1,
    parameter int DATA_LENGTH    = 116,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_new_data_rx,
    input  logic [7:0]        i_data_rx,
    input  logic              i_busy,
    output logic              o_new_data_tx,
    output logic [7:0]        o_data_tx,
    output logic [ADDR_W-1:0] o_addr,
    output logic [CW-1:0]     o_chan,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_drop,
    output logic [7:0]        o_debug
);

    localparam int AB  = arg_bytes(ADDR_W);
    localparam int NB  = DATA_W / 8;
    localparam int ACW = $clog2(AB + 1);
    localparam int LW  = $clog2(READ_LATENCY + 2);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W:0] LEN  = (ADDR_W + 1)'(DATA_LENGTH);
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DATA_LENGTH - 1);

    state_t            r_state;
    logic [7:0]        r_op;
    logic              r_phase;
    logic [ACW-1:0]    r_arg_cnt;
    logic [ADDR_W-1:0] r_shift;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W:0]   r_remaining;
    logic [LW-1:0]     r_lat;
    logic [TW-1:0]     r_timeout;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_chan;
    logic              r_drop;
    logic [7:0]        r_debug;

    logic [ADDR_W-1:0] w_arg;
    logic              w_last_arg;
    logic              w_range_ok;
    logic              w_addr_oor;
    logic              w_load;
    logic              w_done;
    logic [DATA_W-1:0] w_word;

    // Surplus high bits of the first argument byte fall off the top here.
    assign w_arg      = ADDR_W'({r_shift, i_data_rx});
    assign w_last_arg = (r_arg_cnt == ACW'(AB - 1));
    assign w_range_ok = ({1'b0, r_start} < LEN) && (w_arg != '0);
    assign w_addr_oor = ({1'b0, r_addr} >= LEN);
    assign w_load     = (r_state == FETCH) && (r_lat == LW'(READ_LATENCY));
    assign w_word     = w_addr_oor ? {NB{FILL_BYTE}} : i_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= 8'h00;
            r_phase     <= 1'b0;
            r_arg_cnt   <= '0;
            r_shift     <= '0;
            r_start     <= '0;
            r_remaining <= '0;
            r_lat       <= '0;
            r_timeout   <= '0;
            r_addr      <= '0;
            r_chan      <= '0;
            r_drop      <= 1'b0;
            r_debug     <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= '0;
                    r_arg_cnt <= '0;
                    r_phase   <= 1'b0;
                    if (i_new_data_rx) begin
                        r_op <= i_data_rx;
                        case (i_data_rx)
                            OP_SINGLE, OP_RANGE, OP_CHAN: r_state <= GET_ARG;
                            OP_BURST: begin
                                r_addr      <= '0;
                                r_remaining <= LEN;
                                r_lat       <= '0;
                                r_state     <= FETCH;
                            end
                            OP_DROP: begin
                                r_drop <= ~r_drop;
                                r_addr <= '0;
                            end
                            default: r_debug <= i_data_rx;
                        endcase
                    end
                end
                GET_ARG: begin
                    if (i_new_data_rx) begin
                        r_timeout <= '0;
                        r_shift   <= w_arg;
                        r_arg_cnt <= r_arg_cnt + 1'b1;
                        if (r_op == OP_CHAN) begin
                            r_chan  <= CW'({1'b0, i_data_rx} % 9'(CHANNELS));
                            r_state <= IDLE;
                        end else if (w_last_arg) begin
                            r_arg_cnt <= '0;
                            if (r_op == OP_SINGLE) begin
                                r_addr      <= w_arg;
                                r_remaining <= (ADDR_W + 1)'(1);
                                r_lat       <= '0;
                                r_state     <= FETCH;
                            end else if (!r_phase) begin
                                r_start <= w_arg;
                                r_phase <= 1'b1;
                            end else if (w_range_ok) begin
                                r_addr      <= r_start;
                                r_remaining <= {1'b0, w_arg};
                                r_lat       <= '0;
                                r_state     <= FETCH;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_debug <= DBG_TIMEOUT;
                        r_state <= IDLE;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                FETCH: begin
                    if (w_load) r_state <= SEND;
                    else        r_lat   <= r_lat + 1'b1;
                end
                SEND: begin
                    if (w_done) r_state <= NEXT;
                end
                NEXT: begin
                    // Bursts stop at the last valid word even if the count asks for more.
                    if (r_remaining == (ADDR_W + 1)'(1) || {1'b0, r_addr} == LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        r_lat       <= '0;
                        r_state     <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_load),
        .i_word        (w_word),
        .i_busy        (i_busy),
        .o_new_data_tx (o_new_data_tx),
        .o_data_tx     (o_data_tx),
        .o_done        (w_done)
    );

    assign o_addr  = r_addr;
    assign o_chan  = r_chan;
    assign o_drop  = r_drop;
    assign o_debug = r_debug;

endmodule

// File: tb/tb_cmd_data_controller.sv
// Directed bench for cmd_data_controller with 16-bit address/data, 4 channels and a short timeout.
module tb_cmd_data_controller;
    import cmd_pkg::*;

    localparam int DL = 116;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        new_data_rx = 1'b0;
    logic [7:0]  data_rx = 8'h00;
    logic        busy = 1'b0;
    logic        new_data_tx;
    logic [7:0]  data_tx;
    logic [15:0] addr;
    logic [1:0]  chan;
    logic [15:0] data = 16'h0000;
    logic        drop;
    logic [7:0]  debug;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] txq[$];
    int  busy_viol = 0;
    bit  rand_busy = 1'b0;

    cmd_data_controller #(
        .ADDR_W(16), .DATA_W(16), .CHANNELS(4), .DATA_LENGTH(DL),
        .READ_LATENCY(1), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .i_new_data_rx(new_data_rx), .i_data_rx(data_rx),
        .i_busy(busy), .o_new_data_tx(new_data_tx), .o_data_tx(data_tx),
        .o_addr(addr), .o_chan(chan), .i_data(data), .o_drop(drop), .o_debug(debug)
    );

    always #5 clk = ~clk;

    // Memory contents: high byte addr^0x5A, low byte addr + 0x40*chan; unmapped reads return 0x1234.
    function automatic logic [15:0] mem_word(input logic [1:0] ch, input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[7:0] + {ch, 6'd0}};
    endfunction

    always @(posedge clk) data <= (addr < 16'(DL)) ? mem_word(chan, addr) : 16'h1234;

    always @(negedge clk) begin
        if (!rst && new_data_tx) begin
            txq.push_back(data_tx);
            if (busy) busy_viol++;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_busy) busy = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        data_rx = b; new_data_rx = 1'b1;
        @(posedge clk); #1;
        new_data_rx = 1'b0; data_rx = 8'h00;
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int c = 0;
        while (txq.size() < n && c < budget) begin @(posedge clk); #1; c++; end
        ok = (txq.size() >= n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        n_checks++; if (new_data_tx !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", new_data_tx); else n_pass++;
        n_checks++; if (data_tx !== 8'h00) $display("FAIL reset_data_tx: got %h expected 00", data_tx); else n_pass++;
        n_checks++; if (addr !== 16'h0000) $display("FAIL reset_addr: got %h expected 0000", addr); else n_pass++;
        n_checks++; if (chan !== 2'd0) $display("FAIL reset_chan: got %0d expected 0", chan); else n_pass++;
        n_checks++; if (drop !== 1'b0) $display("FAIL reset_drop: got %b expected 0", drop); else n_pass++;
        n_checks++; if (debug !== 8'h00) $display("FAIL reset_debug: got %h expected 00", debug); else n_pass++;
        $display("reset: outputs checked after release");
    endtask

    task automatic test_single;
        bit ok;
        txq.delete();
        send_rx(OP_SINGLE); send_rx(8'h00); send_rx(8'h10);
        wait_tx(2, 200, ok);
        n_checks++; if (!ok) $display("FAIL single_timeout: got %0d bytes expected 2", txq.size()); else n_pass++;
        tick(10);
        n_checks++; if (txq.size() !== 2) $display("FAIL single_count: got %0d expected 2", txq.size()); else n_pass++;
        n_checks++; if (txq[0] !== 8'h4A) $display("FAIL single_msb: got %h expected 4a", txq[0]); else n_pass++;
        n_checks++; if (txq[1] !== 8'h10) $display("FAIL single_lsb: got %h expected 10", txq[1]); else n_pass++;
        n_checks++; if (addr !== 16'h0010) $display("FAIL single_addr: got %h expected 0010", addr); else n_pass++;
        n_checks++; if (dut.r_state !== IDLE) $display("FAIL single_idle: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
        $display("single 0x0010: %0d bytes", txq.size());

        txq.delete();
        send_rx(OP_SINGLE); send_rx(8'h00); send_rx(8'h80);
        wait_tx(2, 200, ok);
        tick(10);
        n_checks++; if (txq.size() !== 2) $display("FAIL single_oor_count: got %0d expected 2", txq.size()); else n_pass++;
        n_checks++; if (txq[0] !== 8'hFF || txq[1] !== 8'hFF) $display("FAIL single_oor_fill: got %h %h expected ff ff", txq[0], txq[1]); else n_pass++;
        $display("single 0x0080 (out of range): %0d bytes", txq.size());
    endtask

    task automatic test_burst;
        bit ok;
        int bad = 0;
        int first_bad = -1;
        logic [15:0] w;
        txq.delete();
        busy_viol = 0;
        rand_busy = 1'b1;
        send_rx(OP_BURST);
        wait_tx(2 * DL, 20000, ok);
        rand_busy = 1'b0;
        busy = 1'b0;
        tick(20);
        n_checks++; if (!ok) $display("FAIL burst_timeout: got %0d bytes expected %0d", txq.size(), 2 * DL); else n_pass++;
        n_checks++; if (txq.size() !== 2 * DL) $display("FAIL burst_count: got %0d expected %0d", txq.size(), 2 * DL); else n_pass++;
        for (int i = 0; i < DL; i++) begin
            w = mem_word(2'd0, 16'(i));
            if (txq[2 * i] !== w[15:8] || txq[2 * i + 1] !== w[7:0]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_checks++; if (bad !== 0) $display("FAIL burst_data: got %0d bad words (first %0d) expected 0", bad, first_bad); else n_pass++;
        n_checks++; if (busy_viol !== 0) $display("FAIL burst_busy: got %0d strobes while busy expected 0", busy_viol); else n_pass++;
        n_checks++; if (addr !== 16'(DL - 1)) $display("FAIL burst_addr: got %h expected %h", addr, 16'(DL - 1)); else n_pass++;
        n_checks++; if (dut.r_state !== IDLE) $display("FAIL burst_idle: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
        $display("burst: %0d bytes, %0d bad words", txq.size(), bad);
    endtask

    task automatic test_range;
        bit ok;
        logic [7:0] exp_bytes [8];
        exp_bytes = '{8'h2A, 8'h70, 8'h2B, 8'h71, 8'h28, 8'h72, 8'h29, 8'h73};
        txq.delete();
        send_rx(OP_RANGE); send_rx(8'h00); send_rx(8'h70); send_rx(8'h00); send_rx(8'h10);
        wait_tx(8, 400, ok);
        tick(20);
        n_checks++; if (txq.size() !== 8) $display("FAIL range_count: got %0d expected 8", txq.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (txq[i] !== exp_bytes[i]) $display("FAIL range_byte%0d: got %h expected %h", i, txq[i], exp_bytes[i]); else n_pass++;
        end
        n_checks++; if (addr !== 16'h0073) $display("FAIL range_addr: got %h expected 0073", addr); else n_pass++;
        $display("range 0x70+0x10: %0d bytes", txq.size());

        txq.delete();
        send_rx(OP_RANGE); send_rx(8'h00); send_rx(8'h05); send_rx(8'h00); send_rx(8'h00);
        tick(30);
        n_checks++; if (txq.size() !== 0) $display("FAIL range_zero_count: got %0d bytes expected 0", txq.size()); else n_pass++;
        n_checks++; if (addr !== 16'h0073) $display("FAIL range_zero_addr: got %h expected 0073", addr); else n_pass++;
        send_rx(OP_RANGE); send_rx(8'h00); send_rx(8'h74); send_rx(8'h00); send_rx(8'h02);
        tick(30);
        n_checks++; if (txq.size() !== 0) $display("FAIL range_oor_start: got %0d bytes expected 0", txq.size()); else n_pass++;
        $display("range rejects: %0d bytes", txq.size());
    endtask

    task automatic test_chan_drop;
        bit ok;
        send_rx(OP_CHAN); send_rx(8'h06);
        tick(3);
        n_checks++; if (chan !== 2'd2) $display("FAIL chan_select: got %0d expected 2", chan); else n_pass++;
        txq.delete();
        send_rx(OP_SINGLE); send_rx(8'h00); send_rx(8'h03);
        wait_tx(2, 200, ok);
        tick(10);
        n_checks++; if (txq.size() !== 2 || txq[0] !== 8'h59 || txq[1] !== 8'h83) $display("FAIL chan_read: got %0d bytes %h %h expected 2 bytes 59 83", txq.size(), txq[0], txq[1]); else n_pass++;
        $display("chan 2 single 0x0003: %0d bytes", txq.size());

        txq.delete();
        send_rx(OP_DROP);
        tick(3);
        n_checks++; if (drop !== 1'b1) $display("FAIL drop_set: got %b expected 1", drop); else n_pass++;
        n_checks++; if (addr !== 16'h0000) $display("FAIL drop_addr: got %h expected 0000", addr); else n_pass++;
        send_rx(OP_DROP);
        tick(3);
        n_checks++; if (drop !== 1'b0) $display("FAIL drop_clear: got %b expected 0", drop); else n_pass++;
        n_checks++; if (txq.size() !== 0) $display("FAIL drop_no_tx: got %0d bytes expected 0", txq.size()); else n_pass++;
        $display("drop toggled twice: drop=%b", drop);
    endtask

    task automatic test_timeout_unknown;
        txq.delete();
        send_rx(OP_SINGLE);
        tick(90);
        n_checks++; if (debug !== 8'h00) $display("FAIL timeout_early: got %h expected 00", debug); else n_pass++;
        n_checks++; if (dut.r_state !== GET_ARG) $display("FAIL timeout_waiting: got %0d expected %0d", dut.r_state, GET_ARG); else n_pass++;
        tick(15);
        n_checks++; if (debug !== DBG_TIMEOUT) $display("FAIL timeout_debug: got %h expected ee", debug); else n_pass++;
        n_checks++; if (dut.r_state !== IDLE) $display("FAIL timeout_idle: got %0d expected %0d", dut.r_state, IDLE); else n_pass++;
        send_rx(8'h99);
        tick(3);
        n_checks++; if (debug !== 8'h99) $display("FAIL unknown_debug: got %h expected 99", debug); else n_pass++;
        n_checks++; if (txq.size() !== 0) $display("FAIL unknown_no_tx: got %0d bytes expected 0", txq.size()); else n_pass++;
        $display("timeout/unknown: debug=%h", debug);
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        int c = 0;
        logic [15:0] w0;
        logic [15:0] w1;
        txq.delete();
        busy = 1'b0;
        send_rx(OP_BURST);
        while (txq.size() < 50 && c < 2000) begin @(negedge clk); #2; c++; end
        n_checks++; if (txq.size() < 50) $display("FAIL midrst_reach: got %0d bytes expected 50", txq.size()); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (new_data_tx !== 1'b0) $display("FAIL midrst_strobe: got %b expected 0", new_data_tx); else n_pass++;
        n_checks++; if (data_tx !== 8'h00) $display("FAIL midrst_data_tx: got %h expected 00", data_tx); else n_pass++;
        n_checks++; if (addr !== 16'h0000) $display("FAIL midrst_addr: got %h expected 0000", addr); else n_pass++;
        n_checks++; if (chan !== 2'd0) $display("FAIL midrst_chan: got %0d expected 0", chan); else n_pass++;
        n_checks++; if (debug !== 8'h00) $display("FAIL midrst_debug: got %h expected 00", debug); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        txq.delete();
        send_rx(OP_BURST);
        wait_tx(4, 200, ok);
        w0 = mem_word(2'd0, 16'h0000);
        w1 = mem_word(2'd0, 16'h0001);
        n_checks++; if (txq[0] !== w0[15:8] || txq[1] !== w0[7:0] || txq[2] !== w1[15:8] || txq[3] !== w1[7:0])
            $display("FAIL midrst_restart: got %h %h %h %h expected %h %h %h %h", txq[0], txq[1], txq[2], txq[3], w0[15:8], w0[7:0], w1[15:8], w1[7:0]);
        else n_pass++;
        wait_tx(2 * DL, 5000, ok);
        tick(10);
        n_checks++; if (txq.size() !== 2 * DL) $display("FAIL midrst_complete: got %0d expected %0d", txq.size(), 2 * DL); else n_pass++;
        $display("reset mid-burst then restart: %0d bytes", txq.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_range();
        test_chan_drop();
        test_timeout_unknown();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
